// File: rtl/conv_pkg.sv
// Shared encodings for the 3x3 convolution MAC engine: FSM states,
// CONTROL word bit positions and datapath widths.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam int CTRL_START = 0;
  localparam int CTRL_ACC   = 1;
  localparam int CTRL_COL   = 2;
  localparam int CTRL_ROW   = 3;

  localparam int N_TAPS = 9;
  localparam int PIX_W  = 8;
  localparam int PROD_W = 17;

endpackage

// File: rtl/conv_tap_mac.sv
// Single-tap multiply-accumulate: unsigned pixel times signed weight,
// sign-extended into a wide accumulator with clear/load/enable control.
module conv_tap_mac
  import conv_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [ACC_W-1:0] load_val,
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] w,
  output logic [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0]  prod_ext;

  // A zero bit above the pixel keeps it non-negative in the signed multiply.
  assign prod     = $signed({1'b0, pix}) * $signed(w);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// 3x3 window dot product over a 4x4 image, one tap per cycle.
// Optional CONV_RELU_EN clamps negative results to zero when sum is written.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int N_TAPS = conv_pkg::N_TAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      image1,
  input  logic [31:0]      image2,
  input  logic [31:0]      image3,
  input  logic [31:0]      image4,
  input  logic [31:0]      filter1,
  input  logic [31:0]      filter2,
  input  logic [31:0]      filter3,
  input  logic [31:0]      control,
  output logic [ACC_W-1:0] sum,
  output logic             busy,
  output logic             done
);

  conv_state_t      state_reg;
  logic             start_q;
  logic [31:0]      img_reg [4];
  logic [71:0]      filt_reg;
  logic             row_off_reg;
  logic             col_off_reg;
  logic [1:0]       r_reg;
  logic [1:0]       c_reg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_next;
  logic [PIX_W-1:0] taps [N_TAPS];
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] w;
  logic [1:0]       row_sel;
  logic [1:0]       col_sel;
  logic [3:0]       tap_idx;
  logic             start_edge;
  logic             unused_ctrl_bits;

  assign unused_ctrl_bits = ^{control[31:4], filter3[31:8]};

  assign start_edge = control[CTRL_START] & ~start_q;
  assign busy       = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_taps
      assign taps[gi] = filt_reg[gi*PIX_W +: PIX_W];
    end
  endgenerate

  // row/col offsets are single bits, so the 2-bit sums never exceed index 3.
  assign row_sel = {1'b0, row_off_reg} + r_reg;
  assign col_sel = {1'b0, col_off_reg} + c_reg;
  assign tap_idx = ({2'b00, r_reg} * 4'd3) + {2'b00, c_reg};
  assign pix     = img_reg[row_sel][{col_sel, 3'b000} +: PIX_W];
  assign w       = taps[tap_idx];

`ifdef CONV_RELU_EN
  assign sum_next = acc[ACC_W-1] ? '0 : acc;
`else
  assign sum_next = acc;
`endif

  conv_tap_mac #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state_reg == IDLE) && start_edge && !control[CTRL_ACC]),
    .load     ((state_reg == IDLE) && start_edge && control[CTRL_ACC]),
    .en       (state_reg == RUN),
    .load_val (sum),
    .pix      (pix),
    .w        (w),
    .acc      (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      start_q     <= 1'b0;
      sum         <= '0;
      done        <= 1'b0;
      r_reg       <= 2'd0;
      c_reg       <= 2'd0;
      row_off_reg <= 1'b0;
      col_off_reg <= 1'b0;
      filt_reg    <= '0;
      for (int i = 0; i < 4; i++) img_reg[i] <= '0;
    end else begin
      start_q <= control[CTRL_START];
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            img_reg[0]  <= image1;
            img_reg[1]  <= image2;
            img_reg[2]  <= image3;
            img_reg[3]  <= image4;
            filt_reg    <= {filter3[7:0], filter2, filter1};
            row_off_reg <= control[CTRL_ROW];
            col_off_reg <= control[CTRL_COL];
            r_reg       <= 2'd0;
            c_reg       <= 2'd0;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          if (c_reg == 2'd2) begin
            c_reg <= 2'd0;
            if (r_reg == 2'd2) state_reg <= DONE;
            else               r_reg     <= r_reg + 2'd1;
          end else begin
            c_reg <= c_reg + 2'd1;
          end
        end
        DONE: begin
          sum       <= sum_next;
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
